// File: rtl/mem_bus_pkg.sv
// Bus command encodings and copy-engine state type, shared by the cpu,
// the top-level decoder and the copy initiator.
package mem_bus_pkg;

    localparam logic [2:0] MNONE  = 3'b001;
    localparam logic [2:0] MREAD  = 3'b010;
    localparam logic [2:0] MWRITE = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } mem_copy_state_t;

endpackage

// File: rtl/mem_copy_initiator.sv
// DMA copy engine: second bus master that copies len words as MREAD/MWRITE pairs.
// Optional MEM_COPY_FILL_EN adds a fill mode that writes a constant word back-to-back.
module mem_copy_initiator
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 16,
    parameter int LEN_W    = 9,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
`ifdef MEM_COPY_FILL_EN
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_data,
`endif
    output logic              busy,
    output logic              done,
    output logic [2:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data
);

    localparam int LAT_W = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LAT);

    mem_copy_state_t   state_q, state_d;
    logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
    logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [DATA_W-1:0] data_buf_q, data_buf_d;
    mem_copy_state_t   word_state;
`ifdef MEM_COPY_FILL_EN
    logic              fill_q, fill_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            src_ptr_q  <= '0;
            dst_ptr_q  <= '0;
            remain_q   <= '0;
            lat_cnt_q  <= '0;
            data_buf_q <= '0;
`ifdef MEM_COPY_FILL_EN
            fill_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            src_ptr_q  <= src_ptr_d;
            dst_ptr_q  <= dst_ptr_d;
            remain_q   <= remain_d;
            lat_cnt_q  <= lat_cnt_d;
            data_buf_q <= data_buf_d;
`ifdef MEM_COPY_FILL_EN
            fill_q     <= fill_d;
`endif
        end
    end

    // Fill mode skips the read phase and stays in WRITE between words.
`ifdef MEM_COPY_FILL_EN
    assign word_state = fill_q ? WRITE : READ;
`else
    assign word_state = READ;
`endif

    always_comb begin
        state_d    = state_q;
        src_ptr_d  = src_ptr_q;
        dst_ptr_d  = dst_ptr_q;
        remain_d   = remain_q;
        lat_cnt_d  = lat_cnt_q;
        data_buf_d = data_buf_q;
`ifdef MEM_COPY_FILL_EN
        fill_d     = fill_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        src_ptr_d = src_addr;
                        dst_ptr_d = dst_addr;
                        remain_d  = len;
                        lat_cnt_d = '0;
`ifdef MEM_COPY_FILL_EN
                        fill_d    = fill;
                        if (fill) begin
                            data_buf_d = fill_data;
                            state_d    = WRITE;
                        end else begin
                            state_d    = READ;
                        end
`else
                        state_d   = READ;
`endif
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            READ: begin
                // Address is held until the responder's data is valid on the last cycle.
                if (lat_cnt_q == LAT_LAST) begin
                    data_buf_d = read_data;
                    lat_cnt_d  = '0;
                    state_d    = WRITE;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            WRITE: begin
                src_ptr_d = src_ptr_q + ADDR_W'(1);
                dst_ptr_d = dst_ptr_q + ADDR_W'(1);
                remain_d  = remain_q - LEN_W'(1);
                state_d   = (remain_q == LEN_W'(1)) ? DONE : word_state;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus outputs decode registered state only, so reset forces MNONE without a clock.
    always_comb begin
        mem_cmd    = MNONE;
        mem_addr   = '0;
        write_data = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            READ: begin
                mem_cmd  = MREAD;
                mem_addr = src_ptr_q;
                busy     = 1'b1;
            end
            WRITE: begin
                mem_cmd    = MWRITE;
                mem_addr   = dst_ptr_q;
                write_data = data_buf_q;
                busy       = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                mem_cmd = MNONE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_copy_initiator.sv
// Scoreboard bench for mem_copy_initiator against a behavioural sync RAM (READ_LAT=1).
module tb_mem_copy_initiator;
    import mem_bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  src_addr = '0;
    logic [8:0]  dst_addr = '0;
    logic [8:0]  len = '0;
`ifdef MEM_COPY_FILL_EN
    logic        fill = 1'b0;
    logic [15:0] fill_data = '0;
`endif
    logic        busy, done;
    logic [2:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;

    logic [15:0] ram [0:511];

    typedef struct {
        logic [2:0]  cmd;
        logic        dn;
        logic [8:0]  addr;
        logic [15:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  n_chk = 0;
    int  n_fail = 0;
    int  bus_cyc = 0;
    int  done_cnt = 0;
    bit  sb_en = 1'b0;

    mem_copy_initiator #(.ADDR_W(9), .DATA_W(16), .LEN_W(9), .READ_LAT(1)) dut (
        .clk(clk), .reset(reset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
`ifdef MEM_COPY_FILL_EN
        .fill(fill), .fill_data(fill_data),
`endif
        .busy(busy), .done(done), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .write_data(write_data), .read_data(read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_cmd == MWRITE) ram[mem_addr] <= write_data;
        read_data <= ram[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every bus cycle or done pulse must match the head of the queue.
    always @(negedge clk) begin
        if (mem_cmd != MNONE) bus_cyc++;
        if (done) done_cnt++;
        if (sb_en && (mem_cmd != MNONE || done)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_bus_event", {28'd0, done, mem_cmd}, 32'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("ev_kind", {28'd0, done, mem_cmd}, {28'd0, e.dn, e.cmd});
                if (!e.dn) chk("ev_addr", {23'd0, mem_addr}, {23'd0, e.addr});
                if (e.cmd == MWRITE) chk("ev_wdata", {16'd0, write_data}, {16'd0, e.data});
            end
        end
    end

    task automatic push_ev(input logic [2:0] cmd, input logic dn, input logic [8:0] a, input logic [15:0] d);
        ev_t e;
        e.cmd = cmd; e.dn = dn; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_word(input logic [8:0] s, input logic [8:0] d, input logic [15:0] v);
        push_ev(MREAD, 1'b0, s, 16'h0);
        push_ev(MREAD, 1'b0, s, 16'h0);
        push_ev(MWRITE, 1'b0, d, v);
    endtask

    task automatic push_done();
        push_ev(MNONE, 1'b1, 9'h0, 16'h0);
    endtask

    task automatic pulse_start(input logic [8:0] s, input logic [8:0] d, input logic [8:0] n);
        @(posedge clk); #1;
        src_addr = s; dst_addr = d; len = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int i;
        for (i = 0; i < max_cyc && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, d0, i;
        for (i = 0; i < 512; i++) ram[i] = 16'h0;
        ram[9'h010] = 16'h00A1; ram[9'h011] = 16'h00B2;
        ram[9'h012] = 16'h00C3; ram[9'h013] = 16'h00D4;
        ram[9'h1FE] = 16'h1111; ram[9'h1FF] = 16'h2222; ram[9'h000] = 16'h3333;

        // Reset state
        #12;
        chk("rst_mem_cmd", {29'd0, mem_cmd}, {29'd0, MNONE});
        chk("rst_mem_addr", {23'd0, mem_addr}, 32'd0);
        chk("rst_wdata", {16'd0, write_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk); reset = 1'b1;

        // Reset mid-copy: async abort, no done pulse
        d0 = done_cnt;
        pulse_start(9'h010, 9'h100, 9'd4);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_mem_cmd", {29'd0, mem_cmd}, {29'd0, MNONE});
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        repeat (2) @(posedge clk);
        chk("midrst_no_done", done_cnt - d0, 32'd0);
        sb_en = 1'b1;

        // Basic 4-word copy
        b0 = bus_cyc; d0 = done_cnt;
        push_word(9'h010, 9'h040, 16'h00A1);
        push_word(9'h011, 9'h041, 16'h00B2);
        push_word(9'h012, 9'h042, 16'h00C3);
        push_word(9'h013, 9'h043, 16'h00D4);
        push_done();
        pulse_start(9'h010, 9'h040, 9'd4);
        chk("copy4_busy", {31'd0, busy}, 32'd1);
        wait_drain(60);
        chk("copy4_bus_cycles", bus_cyc - b0, 32'd12);
        chk("copy4_done_cnt", done_cnt - d0, 32'd1);
        chk("copy4_ram40", {16'd0, ram[9'h040]}, 32'h00A1);
        chk("copy4_ram41", {16'd0, ram[9'h041]}, 32'h00B2);
        chk("copy4_ram42", {16'd0, ram[9'h042]}, 32'h00C3);
        chk("copy4_ram43", {16'd0, ram[9'h043]}, 32'h00D4);

        // Zero-length request
        b0 = bus_cyc;
        push_done();
        pulse_start(9'h010, 9'h050, 9'd0);
        chk("len0_done_next", {31'd0, done}, 32'd1);
        chk("len0_busy", {31'd0, busy}, 32'd0);
        wait_drain(10);
        chk("len0_bus_cycles", bus_cyc - b0, 32'd0);

        // Pointer wrap at the top of the address space
        push_word(9'h1FE, 9'h020, 16'h1111);
        push_word(9'h1FF, 9'h021, 16'h2222);
        push_word(9'h000, 9'h022, 16'h3333);
        push_done();
        pulse_start(9'h1FE, 9'h020, 9'd3);
        wait_drain(40);
        chk("wrap_ram22", {16'd0, ram[9'h022]}, 32'h3333);

        // Start while busy and start during DONE are both ignored
        d0 = done_cnt;
        push_word(9'h010, 9'h060, 16'h00A1);
        push_word(9'h011, 9'h061, 16'h00B2);
        push_done();
        pulse_start(9'h010, 9'h060, 9'd2);
        @(posedge clk); #1;
        src_addr = 9'h013; dst_addr = 9'h070; len = 9'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_during_copy", {31'd0, busy}, 32'd1);
        for (i = 0; i < 30 && !done; i++) begin
            @(posedge clk); #1;
        end
        chk("busy_done_seen", {31'd0, done}, 32'd1);
        src_addr = 9'h013; dst_addr = 9'h070; len = 9'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_drain(20);
        repeat (5) @(posedge clk);
        chk("busy_single_done", done_cnt - d0, 32'd1);
        chk("busy_ram70_untouched", {16'd0, ram[9'h070]}, 32'h0);
        chk("busy_ram61", {16'd0, ram[9'h061]}, 32'h00B2);

`ifdef MEM_COPY_FILL_EN
        // Fill mode: back-to-back writes, no reads
        b0 = bus_cyc;
        for (i = 0; i < 5; i++) push_ev(MWRITE, 1'b0, 9'h080 + 9'(i), 16'hBEEF);
        push_done();
        fill = 1'b1; fill_data = 16'hBEEF;
        pulse_start(9'h000, 9'h080, 9'd5);
        fill = 1'b0;
        wait_drain(20);
        chk("fill_bus_cycles", bus_cyc - b0, 32'd5);
        chk("fill_ram80", {16'd0, ram[9'h080]}, 32'hBEEF);
        chk("fill_ram84", {16'd0, ram[9'h084]}, 32'hBEEF);
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
